rst_release_sequencer: RTL

//  Single-clock reset controller: takes the raw async reset, asserts all downstream

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/rst_sync_nff.sv | 29 ++
 rtl/rst_release_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset release sequencer.
// The helper function sizes index counters that must stay at least 1 bit wide.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD        = 2'd0,
    RELEASE     = 2'd1,
    DONE        = 2'd2,
    SOFT_ASSERT = 2'd3
  } state_e;

  localparam int DEF_NUM_OUT     = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STAGE_DELAY = 16;
  localparam int DEF_DELAY_W     = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_sync_nff.sv
// Reset synchronizer: asserts asynchronously and releases after STAGES clock edges.
// The input of the chain is tied high, so only rst_n clears it.
module rst_sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync
);

  logic [STAGES-1:0] sync_reg;

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("rst_sync_nff: STAGES must be at least 2");
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_reg[STAGES-1];

endmodule

// File: rtl/rst_release_sequencer.sv
// Reset controller: asserts all downstream resets asynchronously, then releases them
// one by one in index order every STAGE_DELAY cycles after a synchronized rst_n release.
module rst_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUT     = DEF_NUM_OUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int DELAY_W     = DEF_DELAY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_rst_req,
  output logic               soft_rst_ack,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               seq_busy,
  output logic               seq_done
);

  localparam int                 IDX_W      = idx_width(NUM_OUT);
  localparam logic [DELAY_W-1:0] LAST_COUNT = DELAY_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_OUT - 1);

  generate
    if (NUM_OUT < 1) begin : g_bad_num_out
      $error("rst_release_sequencer: NUM_OUT must be at least 1");
    end
    if (STAGE_DELAY < 1) begin : g_bad_stage_delay
      $error("rst_release_sequencer: STAGE_DELAY must be at least 1");
    end
    if ((64'd1 << DELAY_W) <= 64'(STAGE_DELAY)) begin : g_bad_delay_w
      $error("rst_release_sequencer: DELAY_W too narrow for STAGE_DELAY");
    end
  endgenerate

  state_e             state_reg, state_next;
  logic [DELAY_W-1:0] count_reg, count_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               armed_reg, armed_next;
  logic               ack_reg, ack_next;
  logic [NUM_OUT-1:0] rst_out_reg, rst_out_next;
  logic [NUM_OUT-1:0] bit_set;
  logic               rst_sync;
  logic               step_en;
  logic               stride_done;
  logic               release_en;

  rst_sync_nff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_sync(rst_sync)
  );

  // The HOLD cycle that sees rst_sync counts as the first stride cycle, so bit k
  // rises exactly (k+1)*STAGE_DELAY edges after rst_sync.
  assign step_en     = (state_reg == RELEASE) || ((state_reg == HOLD) && rst_sync);
  assign stride_done = (count_reg == LAST_COUNT);
  assign release_en  = step_en && stride_done;

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_bit_set
      assign bit_set[gi] = release_en && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    idx_next     = idx_reg;
    armed_next   = soft_rst_req ? armed_reg : 1'b1;
    ack_next     = 1'b0;
    rst_out_next = rst_out_reg | bit_set;

    case (state_reg)
      HOLD, RELEASE: begin
        if (step_en) begin
          state_next = RELEASE;
          if (stride_done) begin
            count_next = '0;
            if (idx_reg == LAST_IDX) begin
              state_next = DONE;
              idx_next   = '0;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end else begin
            count_next = count_reg + DELAY_W'(1);
          end
        end
      end
      DONE: begin
        // Armed flag makes a held-high request fire only once.
        if (soft_rst_req && armed_reg) begin
          state_next   = SOFT_ASSERT;
          rst_out_next = '0;
          armed_next   = 1'b0;
          count_next   = '0;
          idx_next     = '0;
        end
      end
      SOFT_ASSERT: begin
        if (stride_done) begin
          state_next = RELEASE;
          ack_next   = 1'b1;
          count_next = '0;
          idx_next   = '0;
        end else begin
          count_next = count_reg + DELAY_W'(1);
        end
      end
      default: begin
        state_next = HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= HOLD;
      count_reg   <= '0;
      idx_reg     <= '0;
      armed_reg   <= 1'b1;
      ack_reg     <= 1'b0;
      rst_out_reg <= '0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      idx_reg     <= idx_next;
      armed_reg   <= armed_next;
      ack_reg     <= ack_next;
      rst_out_reg <= rst_out_next;
    end
  end

  assign rst_out_n    = rst_out_reg;
  assign soft_rst_ack = ack_reg;
  assign seq_busy     = ~&rst_out_reg;
  assign seq_done     = (state_reg == DONE);

endmodule
